// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the button conditioner.
// Holds the debounce state encoding and the counter-width calculation.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_t;

    // Bits needed to hold the largest of the three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer, debounce FSM, edge pulses and
// hold-to-auto-repeat. All outputs are registered.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic step
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] RD_MAX  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RP_MAX  = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam bit            DB_ONE  = (DEBOUNCE_CYCLES == 1);
    localparam bit            REP_EN  = (REPEAT_DELAY != 0);

    logic            s1, s2;
    btn_state_t      state, state_next;
    logic [CW-1:0]   cnt, cnt_next, cnt_inc;
    logic [CW-1:0]   rep_cnt, rep_cnt_next, rep_inc;
    logic            rep_periodic, rep_periodic_next;
    logic            level_next, rise_next, fall_next, tick;

    // NOTE: every always_ff register uses <= so all flops update from the
    // pre-edge values; blocking here would make s2 copy raw_in in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            state        <= IDLE_LOW;
            cnt          <= '0;
            rep_cnt      <= '0;
            rep_periodic <= 1'b0;
            level        <= 1'b0;
            rise         <= 1'b0;
            fall         <= 1'b0;
            step         <= 1'b0;
        end else begin
            s1           <= raw_in;
            s2           <= s1;
            state        <= state_next;
            cnt          <= cnt_next;
            rep_cnt      <= rep_cnt_next;
            rep_periodic <= rep_periodic_next;
            level        <= level_next;
            rise         <= rise_next;
            fall         <= fall_next;
            step         <= rise_next | tick;
        end
    end

    // NOTE: every signal below gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        cnt_inc           = cnt + CNT_ONE;
        level_next        = level;
        rise_next         = 1'b0;
        fall_next         = 1'b0;
        tick              = 1'b0;
        rep_cnt_next      = '0;
        rep_periodic_next = 1'b0;
        rep_inc           = rep_cnt + CNT_ONE;

        case (state)
            IDLE_LOW: begin
                if (s2) begin
                    if (DB_ONE) begin
                        state_next = IDLE_HIGH;
                        level_next = 1'b1;
                        rise_next  = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next = WAIT_HIGH;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt_inc == DB_MAX) begin
                    state_next = IDLE_HIGH;
                    level_next = 1'b1;
                    rise_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    if (DB_ONE) begin
                        state_next = IDLE_LOW;
                        level_next = 1'b0;
                        fall_next  = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next = WAIT_LOW;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt_inc == DB_MAX) begin
                    state_next = IDLE_LOW;
                    level_next = 1'b0;
                    fall_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase

        // Repeat counter runs only while the accepted level is high; the edge
        // that accepts the release clears it so step never coincides with fall.
        if (REP_EN && (state == IDLE_HIGH || state == WAIT_LOW) && !fall_next) begin
            rep_periodic_next = rep_periodic;
            if (rep_inc == (rep_periodic ? RP_MAX : RD_MAX)) begin
                tick              = 1'b1;
                rep_cnt_next      = '0;
                rep_periodic_next = 1'b1;
            end else begin
                rep_cnt_next      = rep_inc;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_CH raw button/switch inputs into debounced levels, edge pulses
// and auto-repeating step pulses. Channels are fully independent.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] step
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw_in(raw_in[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .step  (step[i])
        );
    end

endmodule
